// File: rtl/multdiv_ctrl_pkg.sv
// Shared constants and state encoding for the multiply/divide sequencer.
package multdiv_ctrl_pkg;

   localparam int unsigned DATA_W_DEF         = 32;
   localparam int unsigned TIMEOUT_CYCLES_DEF = 40;

   localparam logic [4:0] R_TYPE     = 5'b00000;
   localparam logic [4:0] MUL_ALUOP  = 5'b00110;
   localparam logic [4:0] DIV_ALUOP  = 5'b00111;
   localparam logic [4:0] STATUS_REG = 5'd30;

   // Exception codes written to STATUS_REG
   localparam int unsigned ST_MUL_EXC = 4;
   localparam int unsigned ST_DIV_EXC = 5;
   localparam int unsigned ST_TIMEOUT = 6;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_BUSY = 2'd1,
      S_WB   = 2'd2
   } state_e;

endpackage

// File: rtl/multdiv_ctrl_md_watchdog.sv
// BUSY-cycle counter for the multiply/divide sequencer.
// tc_o is registered and reads high in the BUSY cycle where the count
// has reached TIMEOUT_CYCLES, i.e. after TIMEOUT_CYCLES full BUSY cycles.
module multdiv_ctrl_md_watchdog #(
   parameter int unsigned TIMEOUT_CYCLES = multdiv_ctrl_pkg::TIMEOUT_CYCLES_DEF
) (
   input  logic clock_i,
   input  logic reset_ni,
   input  logic clear_i,
   input  logic count_en_i,
   output logic tc_o
);
   import multdiv_ctrl_pkg::*;

   localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

   logic [CNT_W-1:0] count_q, count_d;
   logic             tc_q, tc_d;

   // Next count: clear on accept, count while busy, saturate at terminal count
   always_comb begin
      count_d = count_q;
      if (clear_i) begin
         count_d = '0;
      end else if (count_en_i && (count_q != CNT_W'(TIMEOUT_CYCLES))) begin
         count_d = count_q + CNT_W'(1);
      end
      tc_d = (count_d == CNT_W'(TIMEOUT_CYCLES));
   end

   // Counter and terminal-count flag registers
   always_ff @(posedge clock_i or negedge reset_ni) begin
      if (!reset_ni) begin
         count_q <= '0;
         tc_q    <= 1'b0;
      end else begin
         count_q <= count_d;
         tc_q    <= tc_d;
      end
   end

   assign tc_o = tc_q;

endmodule

// File: rtl/multdiv_ctrl.sv
// Multi-cycle sequencer for the shared multiply/divide unit.
// Optional feature macro: MULTDIV_DIV0_SHORTCUT_EN (divide by zero
// bypasses the unit and writes the divide exception code directly).
module multdiv_ctrl #(
   parameter int unsigned DATA_W         = multdiv_ctrl_pkg::DATA_W_DEF,
   parameter int unsigned TIMEOUT_CYCLES = multdiv_ctrl_pkg::TIMEOUT_CYCLES_DEF,
   parameter logic [4:0]  MUL_ALUOP      = multdiv_ctrl_pkg::MUL_ALUOP,
   parameter logic [4:0]  DIV_ALUOP      = multdiv_ctrl_pkg::DIV_ALUOP,
   parameter logic [4:0]  STATUS_REG     = multdiv_ctrl_pkg::STATUS_REG
) (
   input  logic              clock_i,
   input  logic              reset_ni,
   input  logic              issue_valid_i,
   input  logic [4:0]        opcode_i,
   input  logic [4:0]        aluop_i,
   input  logic [4:0]        rd_i,
   input  logic [DATA_W-1:0] op_b_i,
   input  logic              flush_i,
   input  logic              md_ready_i,
   input  logic              md_exception_i,
   input  logic [DATA_W-1:0] md_result_i,
   output logic              md_ctrl_mult_o,
   output logic              md_ctrl_div_o,
   output logic              stall_o,
   output logic              wb_valid_o,
   output logic [4:0]        wb_rd_o,
   output logic [DATA_W-1:0] wb_data_o,
   output logic              busy_o
);
   import multdiv_ctrl_pkg::*;

   state_e            state_q, state_d;
   logic              op_div_q, op_div_d;
   logic [4:0]        rd_q, rd_d;
   logic              mult_q, mult_d;
   logic              div_q, div_d;
   logic              wb_valid_q, wb_valid_d;
   logic [4:0]        wb_rd_q, wb_rd_d;
   logic [DATA_W-1:0] wb_data_q, wb_data_d;
   logic              busy_q, busy_d;

   logic is_mul_c, is_div_c, match_c, div0_c, ready_ok_c, stall_c;
   logic wd_clear_c, wd_en_c, wd_tc;

   // Instruction decode in the execute stage
   assign is_mul_c = (aluop_i == MUL_ALUOP);
   assign is_div_c = (aluop_i == DIV_ALUOP);
   assign match_c  = issue_valid_i && (opcode_i == R_TYPE) && (is_mul_c || is_div_c) && !flush_i;

`ifdef MULTDIV_DIV0_SHORTCUT_EN
   assign div0_c = is_div_c && (op_b_i == '0);
`else
   logic op_b_unused;
   assign op_b_unused = ^op_b_i;
   assign div0_c      = 1'b0;
`endif

   // md_ready is ignored during the start-pulse cycle
   assign ready_ok_c = md_ready_i && !(mult_q || div_q);

   multdiv_ctrl_md_watchdog #(
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
   ) u_watchdog (
      .clock_i    (clock_i),
      .reset_ni   (reset_ni),
      .clear_i    (wd_clear_c),
      .count_en_i (wd_en_c),
      .tc_o       (wd_tc)
   );

   // Next-state, start-pulse and writeback payload selection
   always_comb begin
      state_d    = state_q;
      op_div_d   = op_div_q;
      rd_d       = rd_q;
      mult_d     = 1'b0;
      div_d      = 1'b0;
      wb_valid_d = 1'b0;
      wb_rd_d    = wb_rd_q;
      wb_data_d  = wb_data_q;
      stall_c    = 1'b0;
      wd_clear_c = 1'b0;
      wd_en_c    = 1'b0;

      unique case (state_q)
         S_IDLE: begin
            stall_c = match_c;
            if (match_c) begin
               rd_d       = rd_i;
               op_div_d   = is_div_c;
               wd_clear_c = 1'b1;
               if (div0_c) begin
                  state_d    = S_WB;
                  wb_valid_d = 1'b1;
                  wb_rd_d    = STATUS_REG;
                  wb_data_d  = DATA_W'(ST_DIV_EXC);
               end else begin
                  state_d = S_BUSY;
                  mult_d  = !is_div_c;
                  div_d   = is_div_c;
               end
            end
         end
         S_BUSY: begin
            stall_c = 1'b1;
            wd_en_c = 1'b1;
            if (flush_i) begin
               state_d = S_IDLE;
            end else if (ready_ok_c) begin
               state_d    = S_WB;
               wb_valid_d = 1'b1;
               if (md_exception_i) begin
                  wb_rd_d   = STATUS_REG;
                  wb_data_d = op_div_q ? DATA_W'(ST_DIV_EXC) : DATA_W'(ST_MUL_EXC);
               end else begin
                  wb_rd_d   = rd_q;
                  wb_data_d = md_result_i;
               end
            end else if (wd_tc) begin
               state_d    = S_WB;
               wb_valid_d = 1'b1;
               wb_rd_d    = STATUS_REG;
               wb_data_d  = DATA_W'(ST_TIMEOUT);
            end
         end
         S_WB: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      busy_d = (state_d != S_IDLE);
   end

   // State and registered outputs
   always_ff @(posedge clock_i or negedge reset_ni) begin
      if (!reset_ni) begin
         state_q    <= S_IDLE;
         op_div_q   <= 1'b0;
         rd_q       <= '0;
         mult_q     <= 1'b0;
         div_q      <= 1'b0;
         wb_valid_q <= 1'b0;
         wb_rd_q    <= '0;
         wb_data_q  <= '0;
         busy_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         op_div_q   <= op_div_d;
         rd_q       <= rd_d;
         mult_q     <= mult_d;
         div_q      <= div_d;
         wb_valid_q <= wb_valid_d;
         wb_rd_q    <= wb_rd_d;
         wb_data_q  <= wb_data_d;
         busy_q     <= busy_d;
      end
   end

   assign md_ctrl_mult_o = mult_q;
   assign md_ctrl_div_o  = div_q;
   assign stall_o        = stall_c;
   assign wb_valid_o     = wb_valid_q;
   assign wb_rd_o        = wb_rd_q;
   assign wb_data_o      = wb_data_q;
   assign busy_o         = busy_q;

endmodule

// File: tb/tb_multdiv_ctrl.sv
// Scoreboard bench for multdiv_ctrl: the driver predicts each writeback
// from the operation's timing rules, a negedge monitor pops and compares.
module tb_multdiv_ctrl;

   localparam int          TMO     = 40;
   localparam logic [4:0]  MUL_OP  = 5'b00110;
   localparam logic [4:0]  DIV_OP  = 5'b00111;
   localparam logic [4:0]  ST_REG  = 5'd30;

   logic        clock = 1'b0;
   logic        reset_n;
   logic        issue_valid, flush, md_ready, md_exception;
   logic [4:0]  opcode, aluop, rd;
   logic [31:0] op_b, md_result;
   logic        md_ctrl_mult, md_ctrl_div, stall, wb_valid, busy;
   logic [4:0]  wb_rd;
   logic [31:0] wb_data;

   typedef struct {
      logic [4:0]  rd;
      logic [31:0] data;
      int          cyc;
   } exp_t;

   exp_t exp_q[$];
   int   checks = 0;
   int   errors = 0;
   int   cyc    = 0;

   multdiv_ctrl #(
      .DATA_W(32), .TIMEOUT_CYCLES(TMO), .MUL_ALUOP(MUL_OP), .DIV_ALUOP(DIV_OP), .STATUS_REG(ST_REG)
   ) dut (
      .clock_i        (clock),
      .reset_ni       (reset_n),
      .issue_valid_i  (issue_valid),
      .opcode_i       (opcode),
      .aluop_i        (aluop),
      .rd_i           (rd),
      .op_b_i         (op_b),
      .flush_i        (flush),
      .md_ready_i     (md_ready),
      .md_exception_i (md_exception),
      .md_result_i    (md_result),
      .md_ctrl_mult_o (md_ctrl_mult),
      .md_ctrl_div_o  (md_ctrl_div),
      .stall_o        (stall),
      .wb_valid_o     (wb_valid),
      .wb_rd_o        (wb_rd),
      .wb_data_o      (wb_data),
      .busy_o         (busy)
   );

   always #5 clock = ~clock;
   always @(posedge clock) cyc <= cyc + 1;

   // Monitor: every writeback strobe must match the oldest prediction
   always @(negedge clock) begin
      if (wb_valid === 1'b1) begin
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_wb: got rd=%0d data=%h at cycle %0d, expected no writeback", wb_rd, wb_data, cyc);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            if (wb_rd !== e.rd || wb_data !== e.data || cyc != e.cyc) begin
               errors++;
               $display("FAIL wb_payload: got rd=%0d data=%h cycle=%0d, expected rd=%0d data=%h cycle=%0d",
                        wb_rd, wb_data, cyc, e.rd, e.data, e.cyc);
            end
         end
      end
   end

   task automatic chk1(input string name, input logic act, input logic exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %b expected %b at cycle %0d", name, act, exp, cyc);
      end
   endtask

   task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at cycle %0d", name, act, exp, cyc);
      end
   endtask

   task automatic next_cycle();
      @(posedge clock);
      #1;
   endtask

   task automatic idle_inputs();
      issue_valid  = 1'b0;
      opcode       = 5'($urandom);
      aluop        = 5'($urandom);
      rd           = 5'($urandom);
      op_b         = $urandom;
      flush        = 1'($urandom);
      md_ready     = 1'($urandom);
      md_exception = 1'($urandom);
      md_result    = $urandom;
   endtask

   task automatic push_exp(input logic [4:0] r, input logic [31:0] d, input int c);
      exp_t e;
      e.rd = r; e.data = d; e.cyc = c;
      exp_q.push_back(e);
   endtask

   task automatic check_all_zero(input string tag);
      chk1({tag, "_mult"}, md_ctrl_mult, 1'b0);
      chk1({tag, "_div"}, md_ctrl_div, 1'b0);
      chk1({tag, "_stall"}, stall, 1'b0);
      chk1({tag, "_wb_valid"}, wb_valid, 1'b0);
      chk1({tag, "_busy"}, busy, 1'b0);
      chk32({tag, "_wb_rd"}, 32'(wb_rd), 32'd0);
      chk32({tag, "_wb_data"}, wb_data, 32'd0);
   endtask

   // One MUL/DIV issue. ready_n: BUSY cycle (1 = start cycle) carrying md_ready,
   // 0 = never. flush_n: BUSY cycle carrying flush, 0 = never.
   task automatic run_op(input bit is_div, input logic [4:0] rd_v, input logic [31:0] opb_v,
                         input int ready_n, input bit exc, input logic [31:0] res,
                         input int flush_n, input bit linger);
      int acc, t_end;
      bit abort, shortcut;
      shortcut = 1'b0;
`ifdef MULTDIV_DIV0_SHORTCUT_EN
      shortcut = is_div && (opb_v == 32'd0);
`endif
      next_cycle();
      idle_inputs();
      issue_valid = 1'b1; opcode = 5'b00000; aluop = is_div ? DIV_OP : MUL_OP;
      rd = rd_v; op_b = opb_v; flush = 1'b0;
      acc = cyc;
      @(negedge clock);
      chk1("accept_stall", stall, 1'b1);
      chk1("accept_busy", busy, 1'b0);

      if (shortcut) begin
         push_exp(ST_REG, 32'd5, acc + 1);
         next_cycle();
         idle_inputs();
         @(negedge clock);
         chk1("div0_stall", stall, 1'b0);
         chk1("div0_no_mult", md_ctrl_mult, 1'b0);
         chk1("div0_no_div", md_ctrl_div, 1'b0);
         chk1("div0_busy", busy, 1'b1);
         return;
      end

      // Reference timing: unit answer counts only from the 2nd BUSY cycle,
      // watchdog ends the wait after TMO full BUSY cycles, flush squashes.
      t_end = TMO + 1;
      if (ready_n >= 2 && ready_n <= TMO + 1) t_end = ready_n;
      abort = (flush_n >= 1 && flush_n <= t_end);
      if (abort) t_end = flush_n;
      else if (ready_n == t_end) begin
         if (exc) push_exp(ST_REG, is_div ? 32'd5 : 32'd4, acc + t_end + 1);
         else     push_exp(rd_v, res, acc + t_end + 1);
      end else begin
         push_exp(ST_REG, 32'd6, acc + t_end + 1);
      end

      for (int n = 1; n <= t_end; n++) begin
         next_cycle();
         idle_inputs();
         issue_valid  = 1'($urandom);
         flush        = (n == flush_n);
         md_ready     = (n == ready_n) || (n == 1 && 1'($urandom));
         md_exception = (n == ready_n) ? exc : 1'($urandom);
         md_result    = (n == ready_n) ? res : $urandom;
         @(negedge clock);
         chk1("busy_stall", stall, 1'b1);
         chk1("busy_flag", busy, 1'b1);
         chk1("start_mult", md_ctrl_mult, (n == 1) && !is_div);
         chk1("start_div", md_ctrl_div, (n == 1) && is_div);
      end

      next_cycle();
      idle_inputs();
      if (abort) begin
         md_ready = 1'b1;
         @(negedge clock);
         chk1("flush_busy", busy, 1'b0);
         chk1("flush_stall", stall, 1'b0);
         next_cycle();
         idle_inputs();
         @(negedge clock);
         chk1("late_ready_busy", busy, 1'b0);
         return;
      end
      // WB cycle: flush and a fresh match must both be ignored
      flush = 1'($urandom);
      if (1'($urandom)) begin
         issue_valid = 1'b1; opcode = 5'b00000; aluop = MUL_OP;
      end
      @(negedge clock);
      chk1("wb_stall", stall, 1'b0);
      chk1("wb_busy", busy, 1'b1);
      chk1("wb_no_mult", md_ctrl_mult, 1'b0);
      if (linger) begin
         next_cycle();
         idle_inputs();
         @(negedge clock);
         chk1("post_wb_busy", busy, 1'b0);
         chk1("post_wb_stall", stall, 1'b0);
      end
   endtask

   task automatic no_stall(input logic [4:0] opc, input logic [4:0] aop, input logic fl, input string name);
      next_cycle();
      idle_inputs();
      issue_valid = 1'b1; opcode = opc; aluop = aop; flush = fl;
      @(negedge clock);
      chk1({name, "_stall"}, stall, 1'b0);
      next_cycle();
      idle_inputs();
      @(negedge clock);
      chk1({name, "_busy"}, busy, 1'b0);
   endtask

   initial begin
      #500000;
      $display("FAIL sim_timeout: got no finish, expected finish before 500000");
      $fatal(1, "timeout");
   end

   initial begin
      bit          d;
      logic [4:0]  r;
      logic [31:0] ob;
      int          rn, fn;

      reset_n = 1'b0;
      idle_inputs();
      repeat (2) @(posedge clock);
      @(negedge clock);
      check_all_zero("reset");
      reset_n = 1'b1;

      // Directed cases
      run_op(1'b0, 5'd7, 32'd1, 4, 1'b0, 32'h0000_002A, 0, 1'b1);
      run_op(1'b1, 5'd12, 32'd3, 3, 1'b1, 32'h1234_5678, 0, 1'b1);
      run_op(1'b0, 5'd3, 32'd9, 0, 1'b0, 32'h0, 0, 1'b1);
      run_op(1'b1, 5'd4, 32'd9, TMO + 1, 1'b0, 32'hCAFE_F00D, 0, 1'b1);
      run_op(1'b0, 5'd5, 32'd2, 6, 1'b0, 32'hDEAD_BEEF, 3, 1'b1);
      run_op(1'b0, 5'd8, 32'd2, 2, 1'b0, 32'h0000_1111, 0, 1'b0);
      run_op(1'b1, 5'd9, 32'd2, 2, 1'b0, 32'h0000_2222, 0, 1'b1);
      run_op(1'b0, 5'd11, 32'd2, 1, 1'b0, 32'h0, 0, 1'b1);
      run_op(1'b0, 5'd0, 32'd2, 5, 1'b1, 32'h5555_0000, 0, 1'b1);
      run_op(1'b0, 5'd0, 32'd2, 5, 1'b0, 32'h5555_0000, 0, 1'b1);
      run_op(1'b1, 5'd13, 32'd0, 3, 1'b0, 32'hFFFF_FFFF, 0, 1'b1);
      no_stall(5'b00000, 5'b00000, 1'b0, "add");
      no_stall(5'b01000, MUL_OP, 1'b0, "non_rtype");
      no_stall(5'b00000, DIV_OP, 1'b1, "flushed_issue");

      // Asynchronous reset in the middle of an operation
      next_cycle();
      idle_inputs();
      issue_valid = 1'b1; opcode = 5'b00000; aluop = MUL_OP; rd = 5'd21; flush = 1'b0;
      repeat (3) begin
         next_cycle();
         idle_inputs();
         md_ready = 1'b0; flush = 1'b0;
      end
      reset_n = 1'b0;
      #1;
      check_all_zero("midreset");
      next_cycle();
      idle_inputs();
      reset_n = 1'b1;
      md_ready = 1'b1; md_exception = 1'b0;
      @(negedge clock);
      chk1("after_reset_busy", busy, 1'b0);

      // Randomized operations
      for (int i = 0; i < 40; i++) begin
         d  = 1'($urandom);
         r  = 5'($urandom);
         ob = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom;
         case ($urandom_range(0, 7))
            0:       rn = 0;
            1:       rn = 1;
            2:       rn = TMO + 1;
            3:       rn = TMO + 2;
            default: rn = $urandom_range(2, 8);
         endcase
         fn = ($urandom_range(0, 5) == 0) ? $urandom_range(1, 6) : 0;
         run_op(d, r, ob, rn, 1'($urandom), $urandom, fn, 1'($urandom));
      end

      next_cycle();
      idle_inputs();
      repeat (3) next_cycle();
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_drain: got %0d pending writebacks, expected 0", exp_q.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
